// File: rtl/syscall_reader.sv
// Read-string syscall engine: takes console bytes over valid/ready, packs them
// little-endian into words and writes a null-terminated string into data memory.
module syscall_reader #(
  parameter logic [31:0] SYS_READ_STR = 32'd8,
  parameter logic [7:0]  NL_CHAR      = 8'h0A
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sys,
  input  logic [31:0] regv,
  input  logic [31:0] rega,
  input  logic [31:0] regb,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        MemWrite,
  output logic [31:0] Addr,
  output logic [31:0] Wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] nchars
);

  typedef enum logic [1:0] {IDLE, RECV, FLUSH, DONE} state_t;

  state_t      state, state_next;
  logic        sys_q;
  logic [31:0] base;
  logic [31:0] limit;
  logic [31:0] word_idx;
  logic [31:0] pack;
  logic [31:0] pack_next;
  logic [1:0]  idx;
  logic        start;
  logic        accept;
  logic        terminate;

  assign in_ready = (state == RECV);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  // sys_q keeps tracking sys through reset, so a strobe held across reset
  // cannot look like a fresh rising edge afterwards.
  always_ff @(posedge clk) begin
    sys_q <= sys;
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    start     = 1'b0;
    accept    = 1'b0;
    terminate = 1'b0;
    pack_next = pack;

    start  = sys && !sys_q && (regv == SYS_READ_STR);
    accept = in_valid && in_ready;
    pack_next[{idx, 3'b000} +: 8] = in_data;
    terminate = accept && ((in_data == NL_CHAR) || (nchars + 32'd1 == limit));
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (regb == 32'd0)      state_next = DONE;
          else if (regb == 32'd1) state_next = FLUSH;
          else                    state_next = RECV;
        end
      end
      RECV:    if (terminate) state_next = FLUSH;
      FLUSH:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base     <= '0;
      limit    <= '0;
      word_idx <= '0;
      pack     <= '0;
      idx      <= '0;
      nchars   <= '0;
      MemWrite <= 1'b0;
      Addr     <= '0;
      Wdata    <= '0;
    end else begin
      MemWrite <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            base     <= rega;
            limit    <= regb - 32'd1;
            word_idx <= '0;
            pack     <= '0;
            idx      <= '0;
            nchars   <= '0;
          end
        end
        RECV: begin
          if (accept) begin
            nchars <= nchars + 32'd1;
            idx    <= idx + 2'd1;
            if (idx == 2'd3) begin
              MemWrite <= 1'b1;
              Addr     <= base + word_idx;
              Wdata    <= pack_next;
              pack     <= '0;
              word_idx <= word_idx + 32'd1;
            end else begin
              pack <= pack_next;
            end
          end
        end
        // Bytes above idx are still zero, so pack is already the padded
        // final word (all zero on a word boundary).
        FLUSH: begin
          MemWrite <= 1'b1;
          Addr     <= base + word_idx;
          Wdata    <= pack;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_syscall_reader.sv
// Self-checking bench for syscall_reader: table of read-string requests checked
// against a byte-level memory model through a write scoreboard, plus reset cases.
module tb_syscall_reader;

  localparam logic [31:0] SYS_CODE = 32'd8;

  logic        clk = 1'b0;
  logic        reset;
  logic        sys;
  logic [31:0] regv, rega, regb;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        MemWrite;
  logic [31:0] Addr, Wdata;
  logic        busy, done;
  logic [31:0] nchars;

  int n_run  = 0;
  int n_fail = 0;
  int cyc    = 0;

  syscall_reader dut (
    .clk(clk), .reset(reset), .sys(sys), .regv(regv), .rega(rega), .regb(regb),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .MemWrite(MemWrite), .Addr(Addr), .Wdata(Wdata),
    .busy(busy), .done(done), .nchars(nchars)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        last;
  } wr_t;

  typedef struct {
    logic [31:0]  n;
    logic [31:0]  base;
    logic [127:0] chars;
    int           len;
    bit           gap;
    logic [31:0]  exp_nchars;
    int           exp_consumed;
    int           exp_lat;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] pack_str(input string s);
    logic [127:0] r = '0;
    for (int i = 0; i < s.len() && i < 16; i++) r[8*i +: 8] = s[i];
    return r;
  endfunction

  // Byte-level model: store up to n-1 chars (stopping after a newline), add
  // the null, then cut the byte image into little-endian words.
  task automatic push_expected(input vec_t v);
    logic [7:0] mem [20];
    int stored = 0;
    int nwords;
    wr_t e;
    if (v.n == 0) return;
    for (int i = 0; i < 20; i++) mem[i] = 8'h00;
    for (int i = 0; i < v.len; i++) begin
      if (stored == int'(v.n) - 1) break;
      mem[stored] = v.chars[8*i +: 8];
      stored++;
      if (v.chars[8*i +: 8] == 8'h0A) break;
    end
    nwords = (stored + 1 + 3) / 4;
    for (int w = 0; w < nwords; w++) begin
      e.addr = v.base + w;
      e.data = {mem[4*w+3], mem[4*w+2], mem[4*w+1], mem[4*w]};
      e.last = (w == nwords - 1);
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (MemWrite === 1'b1) begin
      check("write_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", Addr, e.addr);
        check("write_data", Wdata, e.data);
        check("write_with_done", 32'(done), 32'(e.last));
      end
    end
  end

  task automatic run_vector(input vec_t v, input int id);
    int  k = 0;
    int  start_cyc, acc_cyc, done_cyc;
    bit  seen = 0;
    bit  ready_seen = 0;
    push_expected(v);
    @(negedge clk);
    regv = SYS_CODE; rega = v.base; regb = v.n; sys = 1'b1; in_valid = 1'b0;
    start_cyc = cyc;
    acc_cyc   = cyc;
    done_cyc  = cyc;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      sys = v.gap && (k == 2);  // stray edge mid-read must be ignored
      if (done === 1'b1) begin
        seen     = 1;
        done_cyc = cyc;
        in_valid = 1'b0;
      end else begin
        if (in_ready === 1'b1) ready_seen = 1;
        in_valid = (k < v.len) && !(v.gap && cyc[0]);
        in_data  = v.chars[8*(k & 15) +: 8];
        if (in_valid && in_ready === 1'b1) begin
          acc_cyc = cyc;
          k++;
        end
      end
    end
    check($sformatf("v%0d_done_seen", id), 32'(seen), 32'd1);
    if (seen) begin
      check($sformatf("v%0d_latency", id),
            32'(done_cyc - ((v.n < 2) ? start_cyc : acc_cyc)), 32'(v.exp_lat));
      check($sformatf("v%0d_nchars", id), nchars, v.exp_nchars);
    end
    check($sformatf("v%0d_consumed", id), 32'(k), 32'(v.exp_consumed));
    check($sformatf("v%0d_ready_seen", id), 32'(ready_seen), 32'(v.n >= 2));
    @(negedge clk);
    sys = 1'b0;
    check($sformatf("v%0d_idle_after", id), 32'(busy), 32'd0);
    check($sformatf("v%0d_writes_drained", id), 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1; sys = 1'b0; regv = '0; rega = '0; regb = '0;
    in_valid = 1'b0; in_data = '0;

    vecs[0] = '{32'd16, 32'h10,       pack_str("hi\n"),      3, 1'b0, 32'd3, 3, 2};
    vecs[1] = '{32'd5,  32'h20,       pack_str("abcdefg"),   7, 1'b0, 32'd4, 4, 2};
    vecs[2] = '{32'd16, 32'h30,       pack_str("abc\n"),     4, 1'b0, 32'd4, 4, 2};
    vecs[3] = '{32'd0,  32'h50,       pack_str("zz"),        2, 1'b0, 32'd0, 0, 1};
    vecs[4] = '{32'd1,  32'h60,       pack_str("qq"),        2, 1'b0, 32'd0, 0, 2};
    vecs[5] = '{32'd16, 32'h70,       pack_str("hello\nxy"), 8, 1'b1, 32'd6, 6, 2};
    vecs[6] = '{32'd7,  32'hFFFFFFFF, pack_str("abcdefgh"),  8, 1'b0, 32'd6, 6, 2};
    vecs[7] = '{32'd3,  32'h80,       pack_str("ab"),        2, 1'b0, 32'd2, 2, 2};

    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_memwrite", 32'(MemWrite), 32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_done",     32'(done),     32'd0);
    check("rst_addr",     Addr,          32'd0);
    check("rst_wdata",    Wdata,         32'd0);
    check("rst_nchars",   nchars,        32'd0);
    reset = 1'b0;

    // Rising sys with a different syscall code must not start a read.
    @(negedge clk);
    regv = 32'd4; sys = 1'b1;
    @(negedge clk);
    sys = 1'b0;
    check("other_code_ignored", 32'(busy), 32'd0);

    for (int i = 0; i < 8; i++) run_vector(vecs[i], i);

    // Reset after two stalled bytes of "wxyz", with sys held high throughout.
    @(negedge clk);
    regv = SYS_CODE; rega = 32'h90; regb = 32'd16; sys = 1'b1;
    @(negedge clk); in_valid = 1'b1; in_data = "w";
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); in_valid = 1'b1; in_data = "x";
    @(negedge clk); in_valid = 1'b0;
    check("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("post_reset_busy",     32'(busy),     32'd0);
    check("post_reset_memwrite", 32'(MemWrite), 32'd0);
    check("post_reset_nchars",   nchars,        32'd0);
    repeat (4) @(negedge clk);
    check("held_sys_no_retrigger", 32'(busy), 32'd0);
    sys = 1'b0;
    @(negedge clk);
    run_vector('{32'd16, 32'h90, pack_str("ok\n"), 3, 1'b0, 32'd3, 3, 2}, 8);

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/syscall_reader.md
Name: syscall_reader

Overview:
- Input-side counterpart of the data-memory print-string syscall.
- When the pipeline raises a read-string syscall, it accepts characters from a console byte source over a valid/ready handshake.
- It packs the characters little-endian into 32-bit words: first character in [7:0], matching the print byte order. It writes the words into word-addressed data memory starting at the buffer address in $a0, then null-terminates the string.
- It sits beside the data memory and drives its write port while busy. The pipeline stalls on busy.

Parameters:
- SYS_READ_STR, 8, $v0 code that starts a read.
- NL_CHAR, 8'h0A, terminating character; it is stored before termination.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- sys  input  1  syscall strobe from the pipeline
- regv  input  32  $v0 value, the syscall code
- rega  input  32  $a0 value, buffer base word address
- regb  input  32  $a1 value, buffer size n in characters, including the null
- in_valid  input  1  console byte available
- in_data  input  8  console byte
- in_ready  output  1  byte accepted when in_valid && in_ready
- MemWrite  output  1  data memory word-write strobe, registered
- Addr  output  32  data memory word address, registered
- Wdata  output  32  data memory write data, registered
- busy  output  1  read in progress; pipeline must stall
- done  output  1  one-cycle completion pulse
- nchars  output  32  characters stored, excluding the null; valid from done until the next start

Behaviour:
- Reset (synchronous, active-high): state IDLE. in_ready, MemWrite, busy and done are 0. Addr, Wdata and nchars are 0. Pack buffer, byte index and word index are cleared.
- Reset mid-operation: same as above. Partially packed data is discarded and no write is issued.
- Start condition: rising edge of sys (sys && !sys_q, with sys_q registered) in IDLE with regv == SYS_READ_STR.
  - Base, limit = n-1, byte index and counters are latched.
  - sys edges while not IDLE, or with other regv codes, are ignored.
- States: IDLE, RECV, FLUSH, DONE. busy = (state != IDLE).
- IDLE on start:
  - n == 0 -> DONE: no writes, nchars = 0.
  - n == 1 -> FLUSH: empty string, only the null word is written.
  - otherwise -> RECV.
- RECV:
  - in_ready = 1.
  - On accept: byte goes to buffer[8*idx +: 8]; idx increments mod 4; nchars increments.
  - If accepted at cycle t with idx == 3: cycle t+1 has MemWrite=1, Addr = base + word index, Wdata = packed word. Buffer clears and word index increments.
  - in_ready stays 1 during that write, so back-to-back bytes are accepted every cycle.
  - Termination: accepted byte == NL_CHAR, or nchars reaches limit after the accept. Next state is FLUSH.
- FLUSH: in_ready = 0.
  - MemWrite in this cycle is high only if the terminating byte completed a word.
  - Registers the final write for the next cycle: the partial word zero-padded above idx, or an all-zero word when idx == 0 (word boundary).
  - -> DONE.
- DONE:
  - MemWrite=1 with the null-bearing word (none when n == 0) and done=1, in the same cycle.
  - -> IDLE.
- Guarantees: the string is always null-terminated inside n bytes, with nchars <= n-1. Bytes beyond the terminator in the last word are 0.
- Latency: done asserts exactly 2 cycles after the terminating byte is accepted, and 2 cycles after start for n == 1.
- MemWrite is low in every cycle not listed above.
- in_data is ignored when in_valid = 0. in_valid is ignored when in_ready = 0.
- Addr arithmetic is 32-bit wrapping.

Test Plan:
- "hi\n", n=16, base=0x10:
  - writes 0x000A6968 to 0x10 in the DONE cycle.
  - done is 2 cycles after '\n' is accepted; nchars=3.
  - only one MemWrite.
- "abcdefg", no newline, n=5, base=0x20:
  - stops after 4 chars: word 0x64636261 -> 0x20, then 0x00000000 -> 0x21.
  - in_ready drops after the 4th accept; nchars=4; remaining bytes stay unconsumed.
- "abc\n" at word boundary, n=16:
  - 0x0A636261 -> base at t+1, 0x00000000 -> base+1 with done at t+2.
- n=0 -> done 1 cycle after start, no MemWrite, in_ready never 1.
- n=1 -> 0x00000000 to base, done 2 cycles after start, nchars=0.
- Reset mid-operation: reset after 2 bytes of "wxyz" with in_valid stalled between bytes.
  - next cycle: busy=0, MemWrite=0, no write ever issued.
  - a new start with regv=8 then behaves as a fresh read.
  - sys held high across the reset does not retrigger until it falls and rises again.
